// File: rtl/matmul_seq.sv
//==============================================================================
// Module   : matmul_seq
// Purpose  : Frame sequencer for the UART 3x3 matrix multiplier. Loads A and B
//            from rx bytes, triggers the multiplier, streams the result to tx.
// Option   : MATMUL_SEQ_HDR_EN - each frame must be preceded by HDR_BYTE.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module matmul_seq #(
   parameter logic [7:0] HDR_BYTE = 8'hA5
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic [71:0] o_mat_a,
   output logic [71:0] o_mat_b,
   output logic        o_mm_start,
   input  logic        i_mm_done,
   input  logic [71:0] i_result,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_busy,
   output logic        o_overrun
);

   typedef enum logic [2:0] {
      ST_LOAD_A = 3'd0,
      ST_LOAD_B = 3'd1,
      ST_START  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_SEND   = 3'd4
`ifdef MATMUL_SEQ_HDR_EN
      ,
      ST_HUNT   = 3'd5
`endif
   } state_e;

`ifdef MATMUL_SEQ_HDR_EN
   localparam state_e ST_IDLE = ST_HUNT;
`else
   localparam state_e ST_IDLE = ST_LOAD_A;
   logic w_unused_hdr;
   assign w_unused_hdr = ^HDR_BYTE;
`endif

   state_e      state_q;
   logic [3:0]  idx_q;
   logic [3:0]  idx_d;
   logic [71:0] a_q;
   logic [71:0] b_q;
   logic [71:0] res_q;
   logic        start_q;
   logic        tx_valid_q;
   logic [7:0]  tx_data_q;
   logic        busy_q;
   logic        overrun_q;
   logic        w_rx_drop;

   assign idx_d     = idx_q + 4'd1;
   assign w_rx_drop = i_rx_valid &&
                      (state_q == ST_START || state_q == ST_WAIT || state_q == ST_SEND);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= 4'd0;
         a_q        <= 72'd0;
         b_q        <= 72'd0;
         res_q      <= 72'd0;
         start_q    <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'd0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         start_q <= 1'b0;
         if (w_rx_drop) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
`ifdef MATMUL_SEQ_HDR_EN
            ST_HUNT: begin
               if (i_rx_valid && i_rx_data == HDR_BYTE) begin
                  state_q <= ST_LOAD_A;
                  idx_q   <= 4'd0;
               end
            end
`endif
            ST_LOAD_A: begin
               if (i_rx_valid) begin
                  a_q[{idx_q, 3'b000} +: 8] <= i_rx_data;
                  if (idx_q == 4'd8) begin
                     idx_q   <= 4'd0;
                     state_q <= ST_LOAD_B;
                     busy_q  <= 1'b1;
                  end else begin
                     idx_q <= idx_d;
                  end
               end
            end
            ST_LOAD_B: begin
               if (i_rx_valid) begin
                  b_q[{idx_q, 3'b000} +: 8] <= i_rx_data;
                  if (idx_q == 4'd8) begin
                     idx_q   <= 4'd0;
                     state_q <= ST_START;
                     start_q <= 1'b1;
                  end else begin
                     idx_q <= idx_d;
                  end
               end
            end
            ST_START: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (i_mm_done) begin
                  res_q      <= i_result;
                  idx_q      <= 4'd0;
                  tx_valid_q <= 1'b1;
                  tx_data_q  <= i_result[7:0];
                  state_q    <= ST_SEND;
               end
            end
            ST_SEND: begin
               // tx_data_q only moves on a handshake, so it is stable under backpressure
               if (i_tx_ready) begin
                  if (idx_q == 4'd8) begin
                     tx_valid_q <= 1'b0;
                     idx_q      <= 4'd0;
                     busy_q     <= 1'b0;
                     state_q    <= ST_IDLE;
                  end else begin
                     idx_q     <= idx_d;
                     tx_data_q <= res_q[{idx_d, 3'b000} +: 8];
                  end
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               idx_q      <= 4'd0;
               tx_valid_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign o_mat_a    = a_q;
   assign o_mat_b    = b_q;
   assign o_mm_start = start_q;
   assign o_tx_data  = tx_data_q;
   assign o_tx_valid = tx_valid_q;
   assign o_busy     = busy_q;
   assign o_overrun  = overrun_q;

endmodule

`default_nettype wire

// File: doc/matmul_seq.md
# matmul_seq

- Frame-level sequencer for the UART 3x3 matrix multiplier.
- Collects 18 operand bytes from the UART receiver into matrices A and B, then pulses the multiplier start.
- Captures the 9-byte result and streams it to the UART transmitter with a valid/ready handshake.
- Sits between `receiver`, `matmul` and the transmit path; replaces the ad-hoc load and trigger glue at top level.

## Interface
Parameters:
- `HDR_BYTE`, default 8'hA5: frame sync byte. Used only when `MATMUL_SEQ_HDR_EN` is defined.

Ports:
- `i_clk` input 1: system clock. One clock; reset is synchronous and active-high.
- `i_rst` input 1: synchronous active-high reset.
- `i_rx_data` input 8: received byte.
- `i_rx_valid` input 1: one-cycle pulse; `i_rx_data` is valid in that cycle.
- `o_mat_a` output 72: operand A, row-major; cell k at bits [8k+7:8k].
- `o_mat_b` output 72: operand B, same layout.
- `o_mm_start` output 1: one-cycle trigger to the multiplier.
- `i_mm_done` input 1: pulse; `i_result` is valid in that cycle.
- `i_result` input 72: product, same layout.
- `o_tx_data` output 8: byte to transmit.
- `o_tx_valid` output 1: `o_tx_data` is valid.
- `i_tx_ready` input 1: transmitter can accept a byte.
- `o_busy` output 1: high in any state other than LOAD_A/HUNT.
- `o_overrun` output 1: sticky; set when an rx byte arrives outside the load states.

## Operation
States:
- HUNT (only with the header feature)
- LOAD_A, LOAD_B
- START, WAIT
- SEND

Transitions:
- **HUNT:** an rx byte equal to `HDR_BYTE` -> LOAD_A. Any other byte is discarded and does not set overrun.
- **LOAD_A:** each `i_rx_valid` writes cell `idx` of A, then `idx` increments. The write at `idx`=8 sets `idx`=0 and -> LOAD_B.
- **LOAD_B:** same scheme on B. The write at `idx`=8 -> START.
- **START:** `o_mm_start`=1 for exactly one cycle -> WAIT.
- **WAIT:** on `i_mm_done`, latch `i_result` into the internal result register, set `idx`=0 -> SEND.
  - `o_mat_a`/`o_mat_b` hold their values throughout WAIT and SEND.
- **SEND:** `o_tx_valid`=1 and `o_tx_data`=result cell `idx`.
  - A handshake (valid & ready in the same cycle) advances `idx`.
  - The handshake at `idx`=8 deasserts valid next cycle -> LOAD_A (HUNT if hdr).
  - `o_tx_data` is stable while valid is high and ready is low.

Rules and boundary conditions:
- Bytes are passed through unmodified; no arithmetic in this block. Result width and truncation belong to the multiplier.
- An rx byte in START/WAIT/SEND is dropped and sets `o_overrun`. Buffers and `idx` are unaffected.
- `o_overrun` clears only on reset.
- `i_mm_done` outside WAIT is ignored.
- `i_rx_valid` coinciding with the LOAD_B->START transition counts as overrun; the byte is not written.
- Reset mid-frame: partial operands are discarded and the next frame starts from cell 0 of A.

## Timing
Reset values:
- State = LOAD_A (HUNT with hdr), `idx`=0.
- `o_mat_a`=`o_mat_b`=0, result register=0.
- `o_mm_start`=0, `o_tx_valid`=0, `o_tx_data`=0, `o_busy`=0, `o_overrun`=0.

Latencies:
- Registered cell write: visible on `o_mat_*` the cycle after the `i_rx_valid` pulse.
- 18th byte accepted at cycle N -> `o_mm_start` high at N+1.
- `i_mm_done` at cycle M -> `o_tx_valid` high with cell 0 at M+1.
- Back-to-back ready: one byte per cycle, so 9 bytes occupy M+1..M+9.
- After the final handshake at cycle T, LOAD_A accepts an rx byte at T+1.
- No combinational path from any input to any output. All outputs are registered.

## Configuration
Macro: `MATMUL_SEQ_HDR_EN`.
- **Defined:**
  - The HUNT state exists.
  - Every frame must be preceded by `HDR_BYTE`.
  - The state after reset and after SEND is HUNT.
- **Undefined:**
  - No HUNT state; frames are exactly 18 raw bytes.
  - Return to LOAD_A after SEND and after reset.
  - `HDR_BYTE` is unused.

## Test plan
- **Identity:** reset, A = identity (01,00,00,00,01,00,00,00,01), B = 01..09, model multiplier done 3 cycles after start.
  - Required: one `o_mm_start` pulse exactly 1 cycle after the 18th byte.
  - Required: tx bytes 01..09 in order.
- **Backpressure:** hold `i_tx_ready`=0 for 5 cycles on every byte.
  - Required: `o_tx_data` stable while valid is high.
  - Required: exactly 9 handshakes; `o_busy` falls the cycle after the 9th handshake.
- **Overrun:** send 0x7F during WAIT.
  - Required: `o_overrun`=1 and stays set.
  - Required: result bytes unchanged.
  - Required: the next frame loads normally with A cell 0 = first new byte.
- **Reset mid-frame:** assert `i_rst` after 11 bytes, then send a full frame of A=all 02, B=all 03.
  - Required: `o_mat_a`=72'h020202020202020202.
  - Required: `o_mat_b`=72'h030303030303030303.
  - Required: `o_overrun`=0.
- **Header (`MATMUL_SEQ_HDR_EN`):** send 0x11, 0xA5, then 18 bytes.
  - Required: 0x11 is ignored without overrun.
  - Required: the frame is processed.
  - Required: a frame of 18 bytes without a header produces no `o_mm_start`.
- **Spurious done:** pulse `i_mm_done` during LOAD_B.
  - Required: no state change.
  - Required: no tx activity until the real done pulse after start.
